// File: rtl/control_splitter.sv
// rtl/control_splitter.sv - snapshot a packed word vector and stream it out one word per read.
// Optional SPLITTER_CHECKSUM_EN appends an XOR-of-all-words checksum word to the stream.
module control_splitter #(
   parameter int NUM_BLOCKS = 64,
   parameter int WORD_W     = 16
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_BLOCKS*WORD_W-1:0] combinedin,
   input  logic                         capture,
   input  logic                         read,
   output logic [WORD_W-1:0]            signal,
   output logic [5:0]                   blockaddress,
   output logic                         empty,
   output logic                         done,
   output logic                         underrun
);

`ifdef SPLITTER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, STREAM, CKSUM} state_t;
   // Address 64 does not fit in six bits, so a full-size snapshot reports 63.
   localparam logic [5:0] CKSUM_ADDR = (NUM_BLOCKS == 64) ? 6'd63 : 6'(NUM_BLOCKS);
   logic [WORD_W-1:0] r_cksum;
`else
   typedef enum logic [1:0] {IDLE, STREAM} state_t;
`endif

   localparam logic [5:0] LAST_IDX = 6'(NUM_BLOCKS - 1);

   state_t                         r_state;
   logic [5:0]                     r_index;
   logic [NUM_BLOCKS*WORD_W-1:0]   r_snap;
   logic                           r_done;
   logic                           r_underrun;
   logic [WORD_W-1:0]              w_word;

   assign w_word = r_snap[int'(r_index)*WORD_W +: WORD_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_index    <= '0;
         r_snap     <= '0;
         r_done     <= 1'b0;
         r_underrun <= 1'b0;
`ifdef SPLITTER_CHECKSUM_EN
         r_cksum    <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         // Capture overrides everything, including a simultaneous read.
         if (capture) begin
            r_snap     <= combinedin;
            r_index    <= '0;
            r_state    <= STREAM;
            r_underrun <= 1'b0;
`ifdef SPLITTER_CHECKSUM_EN
            r_cksum    <= '0;
`endif
         end else begin
            case (r_state)
               IDLE: begin
                  if (read)
                     r_underrun <= 1'b1;
               end
               STREAM: begin
                  if (read) begin
`ifdef SPLITTER_CHECKSUM_EN
                     r_cksum <= r_cksum ^ w_word;
`endif
                     if (r_index == LAST_IDX) begin
                        r_index <= '0;
`ifdef SPLITTER_CHECKSUM_EN
                        r_state <= CKSUM;
`else
                        r_state <= IDLE;
                        r_done  <= 1'b1;
`endif
                     end else begin
                        r_index <= r_index + 6'd1;
                     end
                  end
               end
`ifdef SPLITTER_CHECKSUM_EN
               CKSUM: begin
                  if (read) begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                  end
               end
`endif
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      signal       = '0;
      blockaddress = '0;
      empty        = 1'b1;
      case (r_state)
         STREAM: begin
            signal       = w_word;
            blockaddress = r_index;
            empty        = 1'b0;
         end
`ifdef SPLITTER_CHECKSUM_EN
         CKSUM: begin
            signal       = r_cksum;
            blockaddress = CKSUM_ADDR;
            empty        = 1'b0;
         end
`endif
         default: ;
      endcase
   end

   assign done     = r_done;
   assign underrun = r_underrun;

endmodule

// File: tb/tb_control_splitter.sv
// tb/tb_control_splitter.sv - directed self-checking bench for control_splitter.
// Define SPLITTER_CHECKSUM_EN to exercise the checksum word.
module tb_control_splitter;
   localparam int NB = 64;
   localparam int WW = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NB*WW-1:0]  combinedin;
   logic              capture;
   logic              read;
   logic [WW-1:0]     signal;
   logic [5:0]        blockaddress;
   logic              empty;
   logic              done;
   logic              underrun;

   int checks = 0;
   int errors = 0;

   control_splitter #(.NUM_BLOCKS(NB), .WORD_W(WW)) dut (
      .clk(clk), .reset_n(reset_n), .combinedin(combinedin), .capture(capture),
      .read(read), .signal(signal), .blockaddress(blockaddress), .empty(empty),
      .done(done), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [15:0] base);
      for (int k = 0; k < NB; k++)
         combinedin[k*WW +: WW] = base + 16'(k);
   endtask

   task automatic do_capture();
      capture = 1'b1;
      tick();
      capture = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; capture = 1'b0; read = 1'b0; combinedin = '0;
      #3;
      check("rst_signal", 32'(signal), 32'h0);
      check("rst_addr", 32'(blockaddress), 32'h0);
      check("rst_empty", 32'(empty), 32'h1);
      check("rst_done", 32'(done), 32'h0);
      check("rst_underrun", 32'(underrun), 32'h0);
      tick(); tick();
      reset_n = 1'b1;

      // Read while idle sets sticky underrun; capture clears it.
      read = 1'b1; tick(); read = 1'b0;
      check("ur_set", 32'(underrun), 32'h1);
      check("ur_signal", 32'(signal), 32'h0);
      check("ur_empty", 32'(empty), 32'h1);
      tick();
      check("ur_sticky", 32'(underrun), 32'h1);
      load(16'h0100);
      do_capture();
      check("ur_clear", 32'(underrun), 32'h0);
      check("cap_addr", 32'(blockaddress), 32'h0);
      check("cap_empty", 32'(empty), 32'h0);

      // Full stream at one word per cycle.
      read = 1'b1;
      for (int k = 0; k < NB; k++) begin
         check($sformatf("stream_sig%0d", k), 32'(signal), 32'h0100 + k);
         check($sformatf("stream_addr%0d", k), 32'(blockaddress), 32'(k));
         check($sformatf("stream_done%0d", k), 32'(done), 32'h0);
         tick();
      end
      read = 1'b0;
`ifdef SPLITTER_CHECKSUM_EN
      check("ck1_signal", 32'(signal), 32'h0);
      check("ck1_empty", 32'(empty), 32'h0);
      check("ck1_addr", 32'(blockaddress), 32'd63);
      check("ck1_done", 32'(done), 32'h0);
      read = 1'b1; tick(); read = 1'b0;
`endif
      check("end_done", 32'(done), 32'h1);
      check("end_empty", 32'(empty), 32'h1);
      check("end_underrun", 32'(underrun), 32'h0);
      tick();
      check("end_done_once", 32'(done), 32'h0);

      // Capture wins over a simultaneous read.
      do_capture();
      read = 1'b1;
      repeat (10) tick();
      read = 1'b0;
      check("mid_addr", 32'(blockaddress), 32'd10);
      check("mid_signal", 32'(signal), 32'h010A);
      load(16'h2000);
      capture = 1'b1; read = 1'b1; tick(); capture = 1'b0; read = 1'b0;
      check("cr_addr", 32'(blockaddress), 32'h0);
      check("cr_signal", 32'(signal), 32'h2000);
      check("cr_underrun", 32'(underrun), 32'h0);

      // Snapshot isolation from later combinedin changes.
      load(16'h0100);
      do_capture();
      combinedin = '1;
      tick();
      read = 1'b1;
      for (int k = 0; k < 30; k++) begin
         check($sformatf("iso_sig%0d", k), 32'(signal), 32'h0100 + k);
         tick();
      end
      read = 1'b0;
      check("iso_addr30", 32'(blockaddress), 32'd30);

      // Asynchronous reset mid-stream.
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_signal", 32'(signal), 32'h0);
      check("ar_addr", 32'(blockaddress), 32'h0);
      check("ar_empty", 32'(empty), 32'h1);
      check("ar_done", 32'(done), 32'h0);
      check("ar_underrun", 32'(underrun), 32'h0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("ar_hold_done%0d", c), 32'(done), 32'h0);
      end
      reset_n = 1'b1;
      load(16'h0300);
      do_capture();
      check("post_rst_empty", 32'(empty), 32'h0);
      check("post_rst_signal", 32'(signal), 32'h0300);
      check("post_rst_done", 32'(done), 32'h0);

`ifdef SPLITTER_CHECKSUM_EN
      load(16'h0000);
      do_capture();
      read = 1'b1;
      repeat (NB) tick();
      read = 1'b0;
      check("ck2_signal", 32'(signal), 32'h0);
      check("ck2_empty", 32'(empty), 32'h0);
      check("ck2_done", 32'(done), 32'h0);
      read = 1'b1; tick(); read = 1'b0;
      check("ck2_done_pulse", 32'(done), 32'h1);
      check("ck2_empty_end", 32'(empty), 32'h1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
